// File: rtl/byte_striping_lanes.sv
// Round-robin byte/K-symbol striper: packs an STP/SDP..END/EDB framed stream into LANES-wide
// registered lane words, IDL-padded. Define SKP_INSERT_EN for periodic SKP ordered-set insertion.
module byte_striping_lanes #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned BITS         = 8,
  parameter int unsigned SKP_INTERVAL = 64
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  input  logic [BITS-1:0]       D,
  input  logic                  DK,
  input  logic                  VALID,
  output logic                  READY,
  output logic [LANES*BITS-1:0] LANE_DATA,
  output logic [LANES-1:0]      LANE_K,
  output logic                  LANE_VALID,
  output logic                  ERR
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  localparam logic [BITS-1:0] KStp = BITS'(8'hFB);
  localparam logic [BITS-1:0] KSdp = BITS'(8'h5C);
  localparam logic [BITS-1:0] KEnd = BITS'(8'hFD);
  localparam logic [BITS-1:0] KEdb = BITS'(8'hFE);
  localparam logic [BITS-1:0] KIdl = BITS'(8'h7C);

`ifdef SKP_INSERT_EN
  localparam logic [BITS-1:0] KCom = BITS'(8'hBC);
  localparam logic [BITS-1:0] KSkp = BITS'(8'h1C);
  localparam int unsigned CntW = $clog2(SKP_INTERVAL + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SKP_INTERVAL);

  typedef enum logic [1:0] {StIdle, StPkt, StSkp} state_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sub_q, sub_d;
  logic            cnt_expired;
`else
  typedef enum logic [0:0] {StIdle, StPkt} state_e;
`endif

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [LANES*BITS-1:0]   buf_q, buf_d;
  logic [LANES-1:0]        bufk_q, bufk_d;
  logic [LANES*BITS-1:0]   lane_data_q;
  logic [LANES-1:0]        lane_k_q;
  logic                    lane_valid_q, err_q;

  logic                    xfer, is_start, is_end;
  logic                    write, pad, emit, err_d;
  logic [IdxW-1:0]         slot;
  logic [LANES*BITS-1:0]   word_data;
  logic [LANES-1:0]        word_k;

`ifdef SKP_INSERT_EN
  assign cnt_expired = (cnt_q >= CntMax);
  assign READY = (state_q != StSkp) && !((state_q == StIdle) && cnt_expired);
`else
  assign READY = 1'b1;
`endif

  assign xfer     = VALID & READY;
  assign is_start = DK && ((D == KStp) || (D == KSdp));
  assign is_end   = DK && ((D == KEnd) || (D == KEdb));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    bufk_d    = bufk_q;
    write     = 1'b0;
    pad       = 1'b0;
    emit      = 1'b0;
    err_d     = 1'b0;
    slot      = idx_q;
    word_data = buf_q;
    word_k    = bufk_q;
`ifdef SKP_INSERT_EN
    cnt_d = cnt_expired ? cnt_q : cnt_q + CntW'(1);
    sub_d = sub_q;
`endif

    case (state_q)
      StIdle: begin
`ifdef SKP_INSERT_EN
        if (cnt_expired) begin
          state_d = StSkp;
        end else
`endif
        if (xfer) begin
          if (is_start) begin
            write   = 1'b1;
            slot    = '0;
            state_d = StPkt;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPkt: begin
        if (xfer) begin
          write = 1'b1;
          if (is_start) begin
            // Framing error: restart the word with this start symbol.
            err_d = 1'b1;
            slot  = '0;
          end else if (is_end) begin
            pad     = 1'b1;
            state_d = StIdle;
          end
        end
      end
`ifdef SKP_INSERT_EN
      StSkp: begin
        emit      = 1'b1;
        word_data = {LANES{(sub_q == 2'd0) ? KCom : KSkp}};
        word_k    = '1;
        sub_d     = sub_q + 2'd1;
        if (sub_q == 2'd3) begin
          state_d = StIdle;
          cnt_d   = '0;
          sub_d   = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (write) begin
      word_data[int'(slot)*BITS +: BITS] = D;
      word_k[slot]                       = DK;
      if (pad) begin
        for (int n = 0; n < int'(LANES); n++) begin
          if (n > int'(slot)) begin
            word_data[n*BITS +: BITS] = KIdl;
            word_k[n]                 = 1'b1;
          end
        end
      end
      buf_d  = word_data;
      bufk_d = word_k;
      if (pad || (slot == LastIdx)) begin
        emit  = 1'b1;
        idx_d = '0;
      end else begin
        idx_d = slot + IdxW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      buf_q        <= '0;
      bufk_q       <= '0;
      lane_data_q  <= '0;
      lane_k_q     <= '0;
      lane_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef SKP_INSERT_EN
      cnt_q        <= '0;
      sub_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      bufk_q       <= bufk_d;
      lane_valid_q <= emit;
      err_q        <= err_d;
      if (emit) begin
        lane_data_q <= word_data;
        lane_k_q    <= word_k;
      end
`ifdef SKP_INSERT_EN
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
`endif
    end
  end

  assign LANE_DATA  = lane_data_q;
  assign LANE_K     = lane_k_q;
  assign LANE_VALID = lane_valid_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_byte_striping_lanes.sv
// Directed, table-driven bench for byte_striping_lanes (LANES=4, BITS=8).
module tb_byte_striping_lanes;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [7:0]  d;
  logic        dk;
  logic        valid;
  logic        ready;
  logic [31:0] lane_data;
  logic [3:0]  lane_k;
  logic        lane_valid;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  byte_striping_lanes #(
    .LANES       (4),
    .BITS        (8),
`ifdef SKP_INSERT_EN
    .SKP_INTERVAL(8)
`else
    .SKP_INTERVAL(64)
`endif
  ) dut (
    .CLK       (clk),
    .RESET_L   (rst_l),
    .D         (d),
    .DK        (dk),
    .VALID     (valid),
    .READY     (ready),
    .LANE_DATA (lane_data),
    .LANE_K    (lane_k),
    .LANE_VALID(lane_valid),
    .ERR       (err)
  );

  typedef struct {
    logic        v;
    logic        k;
    logic [7:0]  d;
    logic        lv;
    logic        er;
    logic [31:0] data;
    logic [3:0]  lk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic k, input logic [7:0] dd,
                              input logic lv, input logic er, input logic [31:0] data,
                              input logic [3:0] lk);
    vec_t r;
    r.v = v; r.k = k; r.d = dd; r.lv = lv; r.er = er; r.data = data; r.lk = lk;
    return r;
  endfunction

  // Drive one cycle, then check the registered outputs just after the edge.
  task automatic apply(input vec_t t, input string tag);
    valid = t.v;
    dk    = t.k;
    d     = t.d;
    @(posedge clk);
    #1;
    chk({tag, " lane_valid"}, 32'(lane_valid), 32'(t.lv));
    chk({tag, " err"},        32'(err),        32'(t.er));
    chk({tag, " lane_data"},  lane_data,       t.data);
    chk({tag, " lane_k"},     32'(lane_k),     32'(t.lk));
    chk({tag, " ready"},      32'(ready),      32'd1);
  endtask

  task automatic add(input logic v, input logic k, input logic [7:0] dd, input logic lv,
                     input logic er, input logic [31:0] data, input logic [3:0] lk);
    vecs.push_back(mk(v, k, dd, lv, er, data, lk));
  endtask

  initial begin
    rst_l = 1'b0;
    valid = 1'b1;
    dk    = 1'b1;
    d     = 8'hFB;
    // Reset held with VALID=1 must keep everything quiet.
    repeat (3) @(posedge clk);
    #1;
    chk("reset lane_valid", 32'(lane_valid), 32'd0);
    chk("reset err",        32'(err),        32'd0);
    chk("reset ready",      32'(ready),      32'd1);
    chk("reset lane_data",  lane_data,       32'h0);
    chk("reset lane_k",     32'(lane_k),     32'h0);
    valid = 1'b0;
    rst_l = 1'b1;

`ifdef SKP_INSERT_EN
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("skp ready cyc%0d", i), 32'(ready), (i < 8) ? 32'd1 : 32'd0);
    end
    // STP offered while the count is expired must wait for the ordered set.
    valid = 1'b1; dk = 1'b1; d = 8'hFB;
    @(posedge clk);
    #1;
    chk("skp enter lane_valid", 32'(lane_valid), 32'd0);
    chk("skp enter ready",      32'(ready),      32'd0);
    for (int w = 0; w < 4; w++) begin
      @(posedge clk);
      #1;
      chk($sformatf("skp word%0d valid", w), 32'(lane_valid), 32'd1);
      chk($sformatf("skp word%0d data", w), lane_data, (w == 0) ? 32'hBCBCBCBC : 32'h1C1C1C1C);
      chk($sformatf("skp word%0d k", w), 32'(lane_k), 32'hF);
      chk($sformatf("skp word%0d ready", w), 32'(ready), (w == 3) ? 32'd1 : 32'd0);
    end
    apply(mk(1, 1, 8'hFB, 0, 0, 32'h1C1C1C1C, 4'hF), "skp stp");
    apply(mk(1, 0, 8'h33, 0, 0, 32'h1C1C1C1C, 4'hF), "skp d1");
    apply(mk(1, 0, 8'hFF, 0, 0, 32'h1C1C1C1C, 4'hF), "skp d2");
    apply(mk(1, 1, 8'hFD, 1, 0, 32'hFDFF33FB, 4'h9), "skp end");
`else
    // Full word
    add(1, 1, 8'hFB, 0, 0, 32'h0, 4'h0);
    add(1, 0, 8'h33, 0, 0, 32'h0, 4'h0);
    add(1, 0, 8'hFF, 0, 0, 32'h0, 4'h0);
    add(1, 1, 8'hFD, 1, 0, 32'hFDFF33FB, 4'h9);
    add(0, 0, 8'h00, 0, 0, 32'hFDFF33FB, 4'h9);
    // Padding
    add(1, 1, 8'hFB, 0, 0, 32'hFDFF33FB, 4'h9);
    add(1, 0, 8'h33, 0, 0, 32'hFDFF33FB, 4'h9);
    add(1, 1, 8'hFD, 1, 0, 32'h7CFD33FB, 4'hD);
    // Multi-word
    add(1, 1, 8'hFB, 0, 0, 32'h7CFD33FB, 4'hD);
    add(1, 0, 8'h01, 0, 0, 32'h7CFD33FB, 4'hD);
    add(1, 0, 8'h02, 0, 0, 32'h7CFD33FB, 4'hD);
    add(1, 0, 8'h03, 1, 0, 32'h030201FB, 4'h1);
    add(1, 0, 8'h04, 0, 0, 32'h030201FB, 4'h1);
    add(1, 0, 8'h05, 0, 0, 32'h030201FB, 4'h1);
    add(1, 0, 8'h06, 0, 0, 32'h030201FB, 4'h1);
    add(1, 1, 8'hFD, 1, 0, 32'hFD060504, 4'h8);
    // Back-to-back packets
    add(1, 1, 8'hFB, 0, 0, 32'hFD060504, 4'h8);
    add(1, 0, 8'h01, 0, 0, 32'hFD060504, 4'h8);
    add(1, 0, 8'h02, 0, 0, 32'hFD060504, 4'h8);
    add(1, 1, 8'hFD, 1, 0, 32'hFD0201FB, 4'h9);
    add(1, 1, 8'hFB, 0, 0, 32'hFD0201FB, 4'h9);
    add(1, 0, 8'h03, 0, 0, 32'hFD0201FB, 4'h9);
    add(1, 0, 8'h04, 0, 0, 32'hFD0201FB, 4'h9);
    add(1, 1, 8'hFD, 1, 0, 32'hFD0403FB, 4'h9);
    // Errors in IDLE
    add(1, 0, 8'h33, 0, 1, 32'hFD0403FB, 4'h9);
    add(1, 1, 8'hFD, 0, 1, 32'hFD0403FB, 4'h9);
    // Start symbol inside a packet
    add(1, 1, 8'hFB, 0, 0, 32'hFD0403FB, 4'h9);
    add(1, 0, 8'h11, 0, 0, 32'hFD0403FB, 4'h9);
    add(1, 1, 8'hFB, 0, 1, 32'hFD0403FB, 4'h9);
    add(1, 0, 8'h22, 0, 0, 32'hFD0403FB, 4'h9);
    add(1, 0, 8'h33, 0, 0, 32'hFD0403FB, 4'h9);
    add(1, 1, 8'hFD, 1, 0, 32'hFD3322FB, 4'h9);
    // SDP ... EDB
    add(1, 1, 8'h5C, 0, 0, 32'hFD3322FB, 4'h9);
    add(1, 0, 8'hAA, 0, 0, 32'hFD3322FB, 4'h9);
    add(1, 1, 8'hFE, 1, 0, 32'h7CFEAA5C, 4'hD);
    // Stalls inside a packet, then END alone in slot 0
    add(1, 1, 8'hFB, 0, 0, 32'h7CFEAA5C, 4'hD);
    add(0, 0, 8'h99, 0, 0, 32'h7CFEAA5C, 4'hD);
    add(1, 0, 8'h11, 0, 0, 32'h7CFEAA5C, 4'hD);
    add(0, 1, 8'hFD, 0, 0, 32'h7CFEAA5C, 4'hD);
    add(1, 0, 8'h22, 0, 0, 32'h7CFEAA5C, 4'hD);
    add(1, 0, 8'h33, 1, 0, 32'h332211FB, 4'h1);
    add(1, 1, 8'hFD, 1, 0, 32'h7C7C7CFD, 4'hF);
    // VALID=0 start symbol must not open a packet
    add(0, 1, 8'hFB, 0, 0, 32'h7C7C7CFD, 4'hF);
    add(1, 0, 8'h33, 0, 1, 32'h7C7C7CFD, 4'hF);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-packet discards the partial word.
    apply(mk(1, 1, 8'hFB, 0, 0, 32'h7C7C7CFD, 4'hF), "rst stp");
    apply(mk(1, 0, 8'h11, 0, 0, 32'h7C7C7CFD, 4'hF), "rst d1");
    valid = 1'b0;
    rst_l = 1'b0;
    #2;
    chk("midrst lane_valid", 32'(lane_valid), 32'd0);
    chk("midrst lane_data",  lane_data,       32'h0);
    chk("midrst lane_k",     32'(lane_k),     32'h0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    apply(mk(1, 0, 8'h44, 0, 1, 32'h0, 4'h0), "post rst data");
    apply(mk(1, 1, 8'hFB, 0, 0, 32'h0, 4'h0), "post rst stp");
    apply(mk(1, 0, 8'h22, 0, 0, 32'h0, 4'h0), "post rst d1");
    apply(mk(1, 0, 8'h33, 0, 0, 32'h0, 4'h0), "post rst d2");
    apply(mk(1, 1, 8'hFD, 1, 0, 32'hFD3322FB, 4'h9), "post rst end");
`endif

    valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
